// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Multi-cycle restoring integer divider, one quotient bit per clock.
//   Signed operands are reduced to magnitudes on acceptance, divided on the
//   unsigned path, and the signs are re-applied in a single FIX cycle.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        request, sampled only while idle
//   signed_op    1 = two's-complement divide, sampled with start
//   dataA        dividend, sampled with start
//   dataB        divisor, sampled with start
//   busy         operation in progress
//   done         one-cycle completion pulse
//   div_by_zero  last completed op had a zero divisor (held with results)
//   quotient     registered quotient
//   remainder    registered remainder
//   dataOut      {remainder, quotient}
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   dataA,
  input  logic [WIDTH-1:0]   dataB,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic [2*WIDTH-1:0] dataOut
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, shifts out as quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic             qneg_q, qneg_d; // negate quotient in FIX
  logic             rneg_q, rneg_d; // negate remainder in FIX (dividend was negative)
  logic             zero_q, zero_d; // divisor of the op in flight was zero
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;

  // Operand magnitudes; unsigned ops pass the raw value through.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = signed_op & dataA[WIDTH-1];
  assign b_neg = signed_op & dataB[WIDTH-1];
  assign a_mag = a_neg ? (~dataA + 1'b1) : dataA;
  assign b_mag = b_neg ? (~dataB + 1'b1) : dataB;

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value fits in WIDTH+1 bits and the trial's MSB is the
  // borrow: set means the subtraction went negative and we restore.
  logic [WIDTH:0] shifted, trial;

  assign shifted = {rem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          count_d = '0;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          zero_d  = (dataB == '0);
          busy_d  = 1'b1;
          state_d = (dataB == '0) ? S_FIX : S_CALC;
        end
      end

      S_CALC: begin
        rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d   = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        count_d = count_q + CW'(1);
        if (count_q == LAST_STEP) state_d = S_FIX;
      end

      S_FIX: begin
        if (zero_q) begin
          // CALC was skipped, so dvd_q still holds |dataA|; re-applying the
          // dividend sign reconstructs dataA exactly.
          quo_d = '1;
          rmd_d = rneg_q ? (~dvd_q + 1'b1) : dvd_q;
        end else begin
          quo_d = qneg_q ? (~dvd_q + 1'b1) : dvd_q;
          rmd_d = rneg_q ? (~rem_q + 1'b1) : rem_q;
        end
        dbz_d   = zero_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign dataOut     = {rmd_q, quo_q};

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Directed bench for seq_divider at WIDTH=32 and WIDTH=8. Expected results
//   are queued when an op is issued and popped when done is seen.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, signed_op;
  logic [31:0] dataA, dataB;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;
  logic [63:0] dataOut;

  logic        start8, signed8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8;
  logic [7:0]  q8, r8;
  logic [15:0] dout8;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .dataA(dataA), .dataB(dataB), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .quotient(quotient), .remainder(remainder),
    .dataOut(dataOut)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_op(signed8),
    .dataA(a8), .dataB(b8), .busy(busy8), .done(done8),
    .div_by_zero(dbz8), .quotient(q8), .remainder(r8),
    .dataOut(dout8)
  );

  typedef struct {
    string       tag;
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept edge is the first tick; operands are scrambled right after it.
  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic s);
    start = 1'b1; dataA = a; dataB = b; signed_op = s;
    tick();
    start = 1'b0; dataA = $urandom; dataB = $urandom; signed_op = $urandom_range(0, 1);
  endtask

  task automatic expect_op(input string tag, input logic [31:0] q, input logic [31:0] r,
                           input logic dz, input int lat);
    exp_t e;
    e.tag = tag; e.q = q; e.r = r; e.dz = dz; e.lat = lat;
    sb.push_back(e);
  endtask

  // Wait (bounded) for done, then compare against the oldest queued result.
  // Leaves the bench in the done cycle.
  task automatic finish_op();
    int   n;
    exp_t e;
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".done"}, {63'd0, done}, 64'd1);
    chk({e.tag, ".latency"}, 64'(n), 64'(e.lat));
    chk({e.tag, ".quotient"}, {32'd0, quotient}, {32'd0, e.q});
    chk({e.tag, ".remainder"}, {32'd0, remainder}, {32'd0, e.r});
    chk({e.tag, ".dataOut"}, dataOut, {e.r, e.q});
    chk({e.tag, ".div_by_zero"}, {63'd0, div_by_zero}, {63'd0, e.dz});
    chk({e.tag, ".busy"}, {63'd0, busy}, 64'd0);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic s, input logic [7:0] q, input logic [7:0] r);
    int   n;
    exp_t e;
    expect_op(tag, {24'd0, q}, {24'd0, r}, 1'b0, 9);
    start8 = 1'b1; a8 = a; b8 = b; signed8 = s;
    tick();
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    n = 0;
    while (!done8 && n < 100) begin tick(); n++; end
    e = sb.pop_front();
    chk({e.tag, ".latency"}, 64'(n), 64'(e.lat));
    chk({e.tag, ".quotient"}, {56'd0, q8}, {32'd0, e.q});
    chk({e.tag, ".remainder"}, {56'd0, r8}, {32'd0, e.r});
    chk({e.tag, ".dataOut"}, {48'd0, dout8}, {48'd0, e.r[7:0], e.q[7:0]});
    chk({e.tag, ".div_by_zero"}, {63'd0, dbz8}, 64'd0);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    e.tag = s ? "rand_signed" : "rand_unsigned";
    e.dz  = 1'b0;
    e.lat = 33;
    if (s) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          pulses;

    reset = 1'b0; start = 1'b0; signed_op = 1'b0; dataA = '0; dataB = '0;
    start8 = 1'b0; signed8 = 1'b0; a8 = '0; b8 = '0;
    #2;
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.done", {63'd0, done}, 64'd0);
    chk("reset.div_by_zero", {63'd0, div_by_zero}, 64'd0);
    chk("reset.dataOut", dataOut, 64'd0);
    #10 reset = 1'b1;   // released between edges
    tick();

    expect_op("u100_7", 32'd14, 32'd2, 1'b0, 33);
    go(32'd100, 32'd7, 1'b0);
    chk("accept.busy", {63'd0, busy}, 64'd1);
    finish_op();
    tick();
    chk("u100_7.done_one_cycle", {63'd0, done}, 64'd0);
    chk("u100_7.hold_q", {32'd0, quotient}, 64'd14);

    expect_op("s-7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 33);
    go(32'hFFFF_FFF9, 32'd2, 1'b1);
    finish_op();

    expect_op("s7_-2", 32'hFFFF_FFFD, 32'd1, 1'b0, 33);
    go(32'd7, 32'hFFFF_FFFE, 1'b1);
    finish_op();

    expect_op("umax_1", 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
    go(32'hFFFF_FFFF, 32'd1, 1'b0);
    finish_op();

    expect_op("s_overflow", 32'h8000_0000, 32'd0, 1'b0, 33);
    go(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    finish_op();

    expect_op("u3_5", 32'd0, 32'd3, 1'b0, 33);
    go(32'd3, 32'd5, 1'b0);
    finish_op();

    // Divide by zero, then two back-to-back issues from the done cycle.
    expect_op("div0", 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
    go(32'd5, 32'd0, 1'b0);
    finish_op();
    expect_op("b2b_9_3", 32'd3, 32'd0, 1'b0, 33);
    go(32'd9, 32'd3, 1'b0);
    finish_op();
    expect_op("b2b_s1000_-10", 32'hFFFF_FF9C, 32'd0, 1'b0, 33);
    go(32'd1000, 32'hFFFF_FFF6, 1'b1);
    finish_op();

    expect_op("div0_signed", 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1, 1);
    go(32'hFFFF_FFFB, 32'd0, 1'b1);
    finish_op();
    tick();

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      rs = i[0];
      if (rb == 0) rb = 32'd1;
      if (rs && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      sb.push_back(model(ra, rb, rs));
      go(ra, rb, rs);
      finish_op();
      tick();
    end

    // start held high with changing operands while busy: only one op runs.
    // 31 edges are spent inside the hold loop, leaving 2 to done.
    expect_op("hold_start", 32'd14, 32'd2, 1'b0, 2);
    start = 1'b1; dataA = 32'd100; dataB = 32'd7; signed_op = 1'b0;
    tick();
    pulses = 0;
    for (int i = 0; i < 31; i++) begin
      dataA = $urandom; dataB = $urandom;
      tick();
      if (done) pulses++;
    end
    start = 1'b0;
    finish_op();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("hold_start.extra_done", 64'(pulses), 64'd0);
    chk("hold_start.idle_busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset mid-CALC.
    go(32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    #2 reset = 1'b0;
    #1;
    chk("abort.busy", {63'd0, busy}, 64'd0);
    chk("abort.done", {63'd0, done}, 64'd0);
    chk("abort.quotient", {32'd0, quotient}, 64'd0);
    chk("abort.remainder", {32'd0, remainder}, 64'd0);
    tick();
    tick();
    #3 reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("abort.no_done", 64'(pulses), 64'd0);

    expect_op("post_reset_100_7", 32'd14, 32'd2, 1'b0, 33);
    go(32'd100, 32'd7, 1'b0);
    finish_op();
    tick();

    // WIDTH=8 instance.
    run8("w8_u200_13", 8'd200, 8'd13, 1'b0, 8'd15, 8'd5);
    tick();
    run8("w8_s-100_7", 8'h9C, 8'd7, 1'b1, 8'hF2, 8'hFE);
    tick();
    run8("w8_s_overflow", 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
